// File: rtl/avr_dmem_if.sv
// rtl/avr_dmem_if.sv - AVR data-memory bus control and status signals
interface avr_dmem_if;
  logic        d_req;
  logic [15:0] d_addr;
  logic        data_write;
  logic        err_clr;
  logic        mem_wait;
  logic        rd_valid;
  logic        addr_err;
  logic [15:0] err_addr;
  logic        proto_err;

  modport master (
    output d_req, d_addr, data_write, err_clr,
    input  mem_wait, rd_valid, addr_err, err_addr, proto_err
  );

  modport slave (
    input  d_req, d_addr, data_write, err_clr,
    output mem_wait, rd_valid, addr_err, err_addr, proto_err
  );
endinterface

// File: rtl/avr_dmem_responder.sv
// rtl/avr_dmem_responder.sv - SRAM responder on the AVR data bus with wait states and error flags
module avr_dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [15:0] BASE        = 16'h0060,
  parameter int          WAIT_STATES = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  avr_dmem_if.slave  dmem,
  inout  wire  [7:0] data
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  localparam logic [1:0]  WS      = 2'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic            cap_write;
  logic            cap_in;
  logic [AW-1:0]   cap_idx;
  logic [7:0]      cap_data;
  logic            mem_wait_q;
  logic            rd_valid_q;
  logic            addr_err_q;
  logic [15:0]     err_addr_q;
  logic            proto_err_q;
  logic [7:0]      mem [DEPTH];

  logic [15:0]     offset;
  logic            in_range;
  logic [AW-1:0]   index;
  logic            addr_evt;
  logic            proto_evt;
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [7:0]      mem_wd;
  logic [7:0]      rd_byte;
  logic            drive_en;

  assign offset   = dmem.d_addr - BASE;
  assign in_range = (dmem.d_addr >= BASE) && (offset < DEPTH_W);
  assign index    = offset[AW-1:0];

  assign addr_evt  = (state == S_IDLE) && dmem.d_req && !in_range;
  assign proto_evt = ((state != S_IDLE) && dmem.d_req) ||
                     ((state == S_RESP) && dmem.data_write);

  // Zero-wait writes commit straight from the bus; delayed writes commit from the capture registers.
  always_comb begin
    mem_we  = (state == S_WAIT) && (cnt == 2'd1) && cap_write && cap_in;
    mem_idx = cap_idx;
    mem_wd  = cap_data;
    if ((WS == 2'd0) && (state == S_IDLE) && dmem.d_req && dmem.data_write && in_range) begin
      mem_we  = 1'b1;
      mem_idx = index;
      mem_wd  = data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && mem_we) mem[mem_idx] <= mem_wd;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      cap_write  <= 1'b0;
      cap_in     <= 1'b0;
      cap_idx    <= '0;
      cap_data   <= 8'h00;
      mem_wait_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dmem.d_req) begin
            cap_write <= dmem.data_write;
            cap_in    <= in_range;
            cap_idx   <= index;
            cap_data  <= data;
            if (WS != 2'd0) begin
              state      <= S_WAIT;
              cnt        <= WS;
              mem_wait_q <= 1'b1;
            end else if (!dmem.data_write) begin
              state      <= S_RESP;
              rd_valid_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            mem_wait_q <= 1'b0;
            if (cap_write) begin
              state <= S_IDLE;
            end else begin
              state      <= S_RESP;
              rd_valid_q <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          rd_valid_q <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          mem_wait_q <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A same-edge error event outranks err_clr, so the flag stays set and err_addr reloads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_err_q  <= 1'b0;
      err_addr_q  <= 16'h0000;
      proto_err_q <= 1'b0;
    end else begin
      if (addr_evt) begin
        addr_err_q <= 1'b1;
        if (!addr_err_q || dmem.err_clr) err_addr_q <= dmem.d_addr;
      end else if (dmem.err_clr) begin
        addr_err_q <= 1'b0;
        err_addr_q <= 16'h0000;
      end
      if (proto_evt) proto_err_q <= 1'b1;
      else if (dmem.err_clr) proto_err_q <= 1'b0;
    end
  end

  assign rd_byte  = cap_in ? mem[cap_idx] : 8'hFF;
  assign drive_en = (state == S_RESP) && !dmem.data_write;
  assign data     = drive_en ? rd_byte : 8'bzzzz_zzzz;

  assign dmem.mem_wait  = mem_wait_q;
  assign dmem.rd_valid  = rd_valid_q;
  assign dmem.addr_err  = addr_err_q;
  assign dmem.err_addr  = err_addr_q;
  assign dmem.proto_err = proto_err_q;

endmodule
